pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage CPU. It shares the single external memory port between instruction fetch (IF) and the MEM stage. It also produces the six-bit `stall` vector consumed by the PC register and every inter-stage register, and the `flush` pulse that clears IF/ID after a branch mispredict. It sits beside the datapath and is the only source of `stall`/`flush`.

---
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates the shared memory port between fetch and MEM,
// and generates the pipeline stall vector and the IF/ID flush.
module pipe_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_inst,
  output logic          if_done,
  input  logic          ms_req,
  input  logic          ms_we,
  input  logic [AW-1:0] ms_addr,
  input  logic [DW-1:0] ms_wdata,
  output logic [DW-1:0] ms_rdata,
  output logic          ms_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  input  logic          stallreq_id,
  input  logic          stallreq_ex,
  input  logic          mispredict,
  output logic [5:0]    stall,
  output logic          flush
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MS_BUSY, TURN} state_t;

  state_t state, state_nxt;
  logic   drop;
  logic   grant_ms, grant_if;
  logic   fin_if, fin_ms, keep_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ms_req && !ms_done)      state_nxt = MS_BUSY;
        else if (if_req && !if_done) state_nxt = IF_BUSY;
      end
      IF_BUSY, MS_BUSY: if (mem_ready) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A fetch that completes while mispredict is high, or after one was seen, is discarded.
  always_comb begin
    grant_ms = (state == IDLE) && ms_req && !ms_done;
    grant_if = (state == IDLE) && !grant_ms && if_req && !if_done;
    fin_if   = (state == IF_BUSY) && mem_ready;
    fin_ms   = (state == MS_BUSY) && mem_ready;
    keep_if  = fin_if && !drop && !mispredict;

    flush = mispredict;
    if (ms_req && !ms_done)                    stall = 6'b011111;
    else if (stallreq_ex)                      stall = 6'b001111;
    else if (stallreq_id)                      stall = 6'b000111;
    else if (if_req && !if_done && !mispredict) stall = 6'b000011;
    else                                       stall = 6'b000000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      ms_done   <= 1'b0;
      if_inst   <= '0;
      ms_rdata  <= '0;
      drop      <= 1'b0;
    end else begin
      if_done <= keep_if;
      ms_done <= fin_ms;

      // Request attributes are latched at grant and held until completion.
      if (grant_ms) begin
        mem_req   <= 1'b1;
        mem_we    <= ms_we;
        mem_addr  <= ms_addr;
        mem_wdata <= ms_wdata;
      end else if (grant_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (fin_if || fin_ms) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      if (fin_if)                                drop <= 1'b0;
      else if ((state == IF_BUSY) && mispredict) drop <= 1'b1;

      if (keep_if)          if_inst  <= mem_rdata;
      if (fin_ms && !mem_we) ms_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fetch, contention, mispredict drop, stall
// priority, load with wait states and mid-transaction reset.
module tb_pipe_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_inst;
  logic          if_done;
  logic          ms_req;
  logic          ms_we;
  logic [AW-1:0] ms_addr;
  logic [DW-1:0] ms_wdata;
  logic [DW-1:0] ms_rdata;
  logic          ms_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stallreq_id;
  logic          stallreq_ex;
  logic          mispredict;
  logic [5:0]    stall;
  logic          flush;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
    .ms_req(ms_req), .ms_we(ms_we), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
    .ms_rdata(ms_rdata), .ms_done(ms_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .mispredict(mispredict),
    .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = '0; ms_req = 0; ms_we = 0; ms_addr = '0; ms_wdata = '0;
    mem_rdata = '0; mem_ready = 0; stallreq_id = 0; stallreq_ex = 0; mispredict = 0;
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ms_done", ms_done, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", stall, 6'b000000);
    chk("rst_flush", flush, 0);
    tick();
    rst = 1'b1;
    tick();

    // Zero-wait fetch
    if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h3C011234;
    #1;
    chk("f0_stall", stall, 6'b000011);
    chk("f0_mem_req", mem_req, 0);
    tick();
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_stall", stall, 6'b000011);
    chk("f1_if_done", if_done, 0);
    tick();
    chk("f2_mem_req", mem_req, 0);
    chk("f2_if_done", if_done, 1);
    chk("f2_if_inst", if_inst, 32'h3C011234);
    chk("f2_stall", stall, 6'b000000);
    if_req = 0; mem_ready = 0;
    tick();
    chk("f3_if_done", if_done, 0);

    // Contention: store wins, fetch follows after TURN
    if_req = 1; if_addr = 32'h104;
    ms_req = 1; ms_we = 1; ms_addr = 32'h200; ms_wdata = 32'hDEADBEEF;
    #1;
    chk("c0_stall", stall, 6'b011111);
    tick();
    chk("c1_mem_req", mem_req, 1);
    chk("c1_mem_we", mem_we, 1);
    chk("c1_mem_addr", mem_addr, 32'h200);
    chk("c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("c1_stall", stall, 6'b011111);
    tick();
    chk("c2_mem_req", mem_req, 1);
    chk("c2_mem_addr", mem_addr, 32'h200);
    chk("c2_ms_done", ms_done, 0);
    tick();
    chk("c3_stall", stall, 6'b011111);
    mem_ready = 1; mem_rdata = 32'h55555555;
    tick();
    chk("c4_ms_done", ms_done, 1);
    chk("c4_mem_req", mem_req, 0);
    chk("c4_stall", stall, 6'b000011);
    chk("c4_ms_rdata", ms_rdata, 0);
    ms_req = 0; ms_we = 0; mem_ready = 0;
    tick();
    chk("c5_ms_done", ms_done, 0);
    chk("c5_mem_req", mem_req, 0);
    tick();
    chk("c6_mem_req", mem_req, 1);
    chk("c6_mem_we", mem_we, 0);
    chk("c6_mem_addr", mem_addr, 32'h104);
    mem_ready = 1; mem_rdata = 32'h11112222;
    tick();
    chk("c7_if_done", if_done, 1);
    chk("c7_if_inst", if_inst, 32'h11112222);
    if_req = 0; mem_ready = 0;
    tick();

    // Mispredict while fetch is in flight
    if_req = 1; if_addr = 32'h108;
    tick();
    chk("m1_mem_req", mem_req, 1);
    if_req = 0; mispredict = 1;
    #1;
    chk("m1_flush", flush, 1);
    chk("m1_stall", stall, 6'b000000);
    tick();
    mispredict = 0; mem_ready = 1; mem_rdata = 32'hBADBAD00;
    #1;
    chk("m2_flush", flush, 0);
    tick();
    chk("m3_if_done", if_done, 0);
    chk("m3_if_inst", if_inst, 32'h11112222);
    chk("m3_mem_req", mem_req, 0);
    mem_ready = 0;
    tick();
    chk("m4_if_done", if_done, 0);
    tick();
    chk("m5_mem_req", mem_req, 0);

    // Mispredict coinciding with completion
    if_req = 1; if_addr = 32'h10C;
    tick();
    if_req = 0; mispredict = 1; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("mc_if_done", if_done, 0);
    chk("mc_if_inst", if_inst, 32'h11112222);
    mispredict = 0; mem_ready = 0;
    tick();

    // Fetch after a dropped one completes normally
    if_req = 1; if_addr = 32'h110; mem_ready = 1; mem_rdata = 32'h0A0B0C0D;
    tick();
    tick();
    chk("fd_if_done", if_done, 1);
    chk("fd_if_inst", if_inst, 32'h0A0B0C0D);
    if_req = 0; mem_ready = 0;
    tick();

    // Stall priority
    stallreq_id = 1; stallreq_ex = 1;
    #1;
    chk("sp_ex_id", stall, 6'b001111);
    stallreq_ex = 0;
    #1;
    chk("sp_id", stall, 6'b000111);
    if_req = 1;
    #1;
    chk("sp_id_over_if", stall, 6'b000111);
    if_req = 0; stallreq_id = 0;
    #1;
    chk("sp_none", stall, 6'b000000);
    tick();

    // Load with 3 wait cycles; address must stay latched
    ms_req = 1; ms_we = 0; ms_addr = 32'h300; mem_rdata = 32'h00000042;
    tick();
    ms_addr = 32'h999;
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_req", mem_req, 1);
      chk("ld_mem_addr", mem_addr, 32'h300);
      chk("ld_ms_done", ms_done, 0);
      tick();
    end
    chk("ld4_mem_addr", mem_addr, 32'h300);
    mem_ready = 1;
    tick();
    chk("ld_done", ms_done, 1);
    chk("ld_rdata", ms_rdata, 32'h42);
    ms_req = 0; mem_ready = 0;
    tick();
    chk("ld_done_end", ms_done, 0);

    // Reset in MS_BUSY
    ms_req = 1; ms_we = 1; ms_addr = 32'h400; ms_wdata = 32'h12345678;
    tick();
    chk("r0_mem_req", mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("r1_mem_req", mem_req, 0);
    chk("r1_mem_addr", mem_addr, 0);
    chk("r1_ms_rdata", ms_rdata, 0);
    ms_req = 0; ms_we = 0;
    tick();
    rst = 1'b1;
    mem_ready = 1;
    tick();
    chk("r2_ms_done", ms_done, 0);
    chk("r2_mem_req", mem_req, 0);
    if_req = 1; if_addr = 32'h500;
    tick();
    chk("r3_mem_req", mem_req, 1);
    chk("r3_mem_addr", mem_addr, 32'h500);
    if_req = 0;
    tick();
    chk("r4_if_done", if_done, 1);
    mem_ready = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
